// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and stall controller for the 5-stage RISC-V core.
// Resolves EX-stage forwarding, load-use bubbles, taken-branch squashes and
// variable-latency data-memory wait states with timeout detection.
// Optional feature macro: HAZARD_PERF_CNT_EN (builds saturating stall/flush
// performance counters; when undefined the counter ports are tied to 0).
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic [1:0]       ResultSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemAckM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCycles
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StErr  = 2'b10
  } memState_t;

  memState_t         memState;
  logic [WCNT_W-1:0] waitCnt;
  logic              memStall;
  logic              lwStall;

  // ---------------------------------------------------------------------------
  // Forwarding: one identical selector per EX operand (0 = A/Rs1E, 1 = B/Rs2E).
  // M has priority over W because it holds the younger result.
  // ---------------------------------------------------------------------------
  logic [1:0][4:0] srcE;
  logic [1:0][1:0] fwdSel;

  assign srcE = {Rs2E, Rs1E};

  for (genvar gi = 0; gi < 2; gi++) begin : gFwd
    assign fwdSel[gi] = !rst                                            ? 2'b00 :
                        (RegWriteM && (RdM != 5'd0) && (RdM == srcE[gi])) ? 2'b10 :
                        (RegWriteW && (RdW != 5'd0) && (RdW == srcE[gi])) ? 2'b01 :
                                                                            2'b00;
  end

  assign ForwardAE = fwdSel[0];
  assign ForwardBE = fwdSel[1];

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  assign lwStall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
  assign memStall = (memState == StErr) ? 1'b1 : (MemReqM && !MemAckM);

  // Prioritised stall/flush pattern; everything is held at 0 while in reset.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (rst) begin
      if (memStall) begin
        // Freeze everything up to M and bubble WB; branch/load-use wait for the ack.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (PCSrcE) begin
        // Squash the two wrong-path instructions; a load-use on the D slot is moot.
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lwStall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  // Data-memory wait-state FSM with timeout; MemErr is a registered, sticky flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memState <= StIdle;
      waitCnt  <= '0;
      MemErr   <= 1'b0;
    end else begin
      case (memState)
        StIdle: begin
          if (MemReqM && !MemAckM) begin
            memState <= StWait;
            waitCnt  <= WCNT_W'(1);
          end
        end
        StWait: begin
          if (!MemReqM || MemAckM) begin
            // Normal completion, or the request was withdrawn.
            memState <= StIdle;
            waitCnt  <= '0;
          end else if (waitCnt == WCNT_W'(MEM_TIMEOUT)) begin
            memState <= StErr;
            MemErr   <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        StErr: begin
          MemErr <= 1'b1;
        end
        default: begin
          memState <= StIdle;
          waitCnt  <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;
  logic             anyStall;
  logic             anyFlush;

  assign anyStall = StallF || StallD || StallE || StallM;
  assign anyFlush = FlushD || FlushE;

  // Saturating performance counters for stalled and squashing cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (anyStall && (stallCnt != '1)) begin
        stallCnt <= stallCnt + 1'b1;
      end
      if (anyFlush && (flushCnt != '1)) begin
        flushCnt <= flushCnt + 1'b1;
      end
    end
  end

  assign StallCycles = stallCnt;
  assign FlushCycles = flushCnt;
`else
  assign StallCycles = '0;
  assign FlushCycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4).
// Counter expectations depend on HAZARD_PERF_CNT_EN in the same way as the DUT.
module tb_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 32;

  // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  localparam logic [6:0] P_NONE = 7'b0000000;
  localparam logic [6:0] P_MEM  = 7'b1111001;
  localparam logic [6:0] P_BR   = 7'b0000110;
  localparam logic [6:0] P_LU   = 7'b1100010;

  logic             clk;
  logic             rst;
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]       ResultSrcE;
  logic             RegWriteM, RegWriteW, PCSrcE, MemReqM, MemAckM;
  logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             MemErr;
  logic [CNT_W-1:0] StallCycles, FlushCycles;

  int errors = 0;
  int checks = 0;
  int expStallCnt = 0;
  int expFlushCnt = 0;

  hazard_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .RdM        (RdM),
    .RdW        (RdW),
    .ResultSrcE (ResultSrcE),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .PCSrcE     (PCSrcE),
    .MemReqM    (MemReqM),
    .MemAckM    (MemAckM),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushW     (FlushW),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .MemErr     (MemErr),
    .StallCycles(StallCycles),
    .FlushCycles(FlushCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
    checks++;
    assert (obs === expVal) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expVal);
    end
  endtask

  // Compare the stall/flush pattern; the edge that follows will count it.
  task automatic expectCtl(input string tag, input logic [6:0] pat);
    check(tag, 32'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}), 32'(pat));
    if (|pat[6:3]) expStallCnt++;
    if (pat[2] | pat[1]) expFlushCnt++;
    $display("step %s: ctl=%b fwdA=%b fwdB=%b memErr=%b", tag,
             {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW},
             ForwardAE, ForwardBE, MemErr);
  endtask

  task automatic checkCnt(input string tag);
`ifdef HAZARD_PERF_CNT_EN
    check({tag, "_stallcnt"}, 32'(StallCycles), 32'(expStallCnt));
    check({tag, "_flushcnt"}, 32'(FlushCycles), 32'(expFlushCnt));
`else
    check({tag, "_stallcnt"}, 32'(StallCycles), 32'd0);
    check({tag, "_flushcnt"}, 32'(FlushCycles), 32'd0);
`endif
  endtask

  // Move to just after the next rising edge; inputs are driven from here.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clearInputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0; ResultSrcE = '0;
    RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; MemReqM = 0; MemAckM = 0;
  endtask

  initial begin
    // ---------------- reset: outputs forced low despite live hazards ----------
    clearInputs();
    rst = 1'b0;
    RegWriteM = 1; RdM = 5; Rs1E = 5; MemReqM = 1;
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; PCSrcE = 1;
    #12;
    expectCtl("rst_ctl", P_NONE);
    check("rst_fwdA", 32'(ForwardAE), 32'd0);
    check("rst_memerr", 32'(MemErr), 32'd0);
    expStallCnt = 0; expFlushCnt = 0;
    checkCnt("rst");
    clearInputs();
    cyc();
    rst = 1'b1;

    // ---------------- forwarding ---------------------------------------------
    cyc(); RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; Rs2E = 0; #1;
    check("fwd_m_pri_A", 32'(ForwardAE), 32'd2);
    check("fwd_m_pri_B", 32'(ForwardBE), 32'd0);
    expectCtl("fwd1", P_NONE);
    cyc(); RegWriteM = 0; #1;
    check("fwd_w_A", 32'(ForwardAE), 32'd1);
    expectCtl("fwd2", P_NONE);
    cyc(); RegWriteM = 1; RdM = 0; Rs2E = 5; #1;
    check("fwd_rd0_A", 32'(ForwardAE), 32'd1);
    check("fwd_w_B", 32'(ForwardBE), 32'd1);
    expectCtl("fwd3", P_NONE);
    cyc(); RdM = 9; Rs2E = 9; #1;
    check("fwd_mix_A", 32'(ForwardAE), 32'd1);
    check("fwd_mix_B", 32'(ForwardBE), 32'd2);
    expectCtl("fwd4", P_NONE);
    cyc(); RegWriteM = 0; RegWriteW = 0; #1;
    check("fwd_none_A", 32'(ForwardAE), 32'd0);
    check("fwd_none_B", 32'(ForwardBE), 32'd0);
    expectCtl("fwd5", P_NONE);

    // ---------------- load-use -----------------------------------------------
    cyc(); clearInputs(); ResultSrcE = 2'b01; RdE = 7; Rs1D = 3; Rs2D = 7; #1;
    expectCtl("lu_rs2", P_LU);
    cyc(); ResultSrcE = 2'b00; RdE = 0; #1;
    expectCtl("lu_bubble_done", P_NONE);
    cyc(); ResultSrcE = 2'b01; RdE = 0; Rs1D = 0; Rs2D = 0; #1;
    expectCtl("lu_rd0", P_NONE);
    cyc(); RdE = 7; Rs1D = 7; #1;
    expectCtl("lu_rs1", P_LU);
    cyc(); ResultSrcE = 2'b10; #1;
    expectCtl("lu_notload", P_NONE);

    // ---------------- branch masks load-use ----------------------------------
    cyc(); ResultSrcE = 2'b01; PCSrcE = 1; #1;
    expectCtl("br_masks_lu", P_BR);
    cyc(); clearInputs(); #1;
    checkCnt("after_br");
    expectCtl("br_done", P_NONE);

    // ---------------- memory wait: 3 wait cycles then ack --------------------
    cyc(); MemReqM = 1; MemAckM = 0; #1;
    expectCtl("mw_c0", P_MEM);
    cyc(); #1;
    expectCtl("mw_c1", P_MEM);
    cyc(); #1;
    expectCtl("mw_c2", P_MEM);
    cyc(); MemAckM = 1; #1;
    expectCtl("mw_ack", P_NONE);
    cyc(); MemReqM = 0; MemAckM = 0; #1;
    checkCnt("after_mw");
    expectCtl("mw_idle", P_NONE);

    // ---------------- same-cycle ack -----------------------------------------
    cyc(); MemReqM = 1; MemAckM = 1; #1;
    expectCtl("ack0_a", P_NONE);
    cyc(); #1;
    expectCtl("ack0_b", P_NONE);

    // ---------------- simultaneous hazards -----------------------------------
    cyc(); MemAckM = 0; PCSrcE = 1; ResultSrcE = 2'b01; RdE = 7; Rs1D = 7; #1;
    expectCtl("sim_mem0", P_MEM);
    cyc(); #1;
    expectCtl("sim_mem1", P_MEM);
    cyc(); MemAckM = 1; #1;
    expectCtl("sim_ack_br", P_BR);
    cyc(); clearInputs(); #1;
    expectCtl("sim_done", P_NONE);

    // ---------------- request withdrawn in WAIT ------------------------------
    cyc(); MemReqM = 1; MemAckM = 0; #1;
    expectCtl("drop_c0", P_MEM);
    cyc(); MemReqM = 0; #1;
    expectCtl("drop_c1", P_NONE);

    // ---------------- timeout: 1 IDLE + MEM_TIMEOUT WAIT cycles -------------
    cyc(); MemReqM = 1; MemAckM = 0; #1;
    expectCtl("to_idle", P_MEM);
    check("to_idle_err", 32'(MemErr), 32'd0);
    for (int k = 1; k <= MEM_TIMEOUT; k++) begin
      cyc(); #1;
      expectCtl($sformatf("to_wait%0d", k), P_MEM);
      check($sformatf("to_wait%0d_err", k), 32'(MemErr), 32'd0);
    end
    cyc(); MemReqM = 0; #1;
    check("err_memerr", 32'(MemErr), 32'd1);
    expectCtl("err_noreq", P_MEM);
    cyc(); MemReqM = 1; MemAckM = 1; PCSrcE = 1; RegWriteM = 1; RdM = 5; Rs1E = 5; #1;
    checkCnt("in_err");
    check("err_sticky", 32'(MemErr), 32'd1);
    expectCtl("err_ack_ignored", P_MEM);

    // ---------------- asynchronous reset mid-ERR -----------------------------
    rst = 1'b0; #1;
    expStallCnt = 0; expFlushCnt = 0;
    expectCtl("rst_err_ctl", P_NONE);
    check("rst_err_fwdA", 32'(ForwardAE), 32'd0);
    check("rst_err_memerr", 32'(MemErr), 32'd0);
    checkCnt("rst_err");
    cyc(); rst = 1'b1; clearInputs(); #1;
    expectCtl("post_rst_idle", P_NONE);
    check("post_rst_memerr", 32'(MemErr), 32'd0);
    cyc(); MemReqM = 1; #1;
    expectCtl("post_rst_req", P_MEM);
    cyc(); MemAckM = 1; #1;
    expectCtl("post_rst_ack", P_NONE);
    cyc(); clearInputs(); #1;
    checkCnt("final");
    expectCtl("final_idle", P_NONE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
